pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline. Drives PC enable plus valid
//  (write-enable) and flush to the IF/ID and ID/EX registers; drives valid to EX/MEM and MEM/WB.
//  Resolves load-use hazards, branch/jump redirects, fetch wait and data-memory wait.
//  Enforces a post-reset priming sequence, a memory-wait watchdog and performance counters.
// PARAMETERS
//  BOOT_CYCLES   2     cycles the pipeline stays flushed after reset release (>=1)
//  MEM_TIMEOUT   64    max consecutive data-memory wait cycles before sticky error (>=2)
//  CNT_W         32    width of stall_cnt / flush_cnt
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      asynchronous, active-high
//  id_rs1        in   5      rs1 of instruction in ID
//  id_rs2        in   5      rs2 of instruction in ID
//  id_rs1_used   in   1      ID instruction reads rs1
//  id_rs2_used   in   1      ID instruction reads rs2
//  ex_rd         in   5      destination reg of instruction in EX
//  ex_mem_read   in   1      EX instruction is a load
//  ex_redirect   in   1      EX resolved taken branch or jump (PC unit selects target)
//  imem_ready    in   1      instruction memory returns valid instruction this cycle
//  mem_req       in   1      MEM stage has a data-memory access
//  mem_ready     in   1      data memory completes access this cycle
//  pc_en         out  1      PC register update enable
//  if_id_valid   out  1      IF/ID write enable;  if_id_flush  out 1  IF/ID clear
//  id_ex_valid   out  1      ID/EX write enable;  id_ex_flush  out 1  ID/EX clear (bubble)
//  ex_mem_valid  out  1      EX/MEM write enable; mem_wb_valid out 1  MEM/WB write enable
//  err           out  1      sticky memory-wait timeout
//  stall_cnt     out  CNT_W  cycles in RUN/MEM_WAIT with pc_en=0, saturating
//  flush_cnt     out  CNT_W  accepted redirects, saturating
// BEHAVIOUR
//  States: BOOT, RUN, MEM_WAIT, ERROR. Reset -> BOOT, boot counter 0, err 0, both counters 0.
//  Outputs are combinational from state+inputs; state/counters registered.
//  BOOT: pc_en=0, all *_valid=0, if_id_flush=id_ex_flush=1 (also while reset is high).
//    After reset release, count BOOT_CYCLES clocks, then go to RUN.
//  RUN, terms:
//    load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used&id_rs1==ex_rd)|(id_rs2_used&id_rs2==ex_rd))
//    mem_busy = mem_req & !mem_ready
//  RUN cases, strict priority, first match wins:
//    1 mem_busy: all enables 0, flushes 0 (freeze); next MEM_WAIT, wait count=1.
//    2 ex_redirect: pc_en=1, if_id_flush=id_ex_flush=1, ex_mem/mem_wb valid=1; flush_cnt++.
//    3 load_use: pc_en=0, if_id_valid=0 (hold), id_ex_flush=1, ex_mem/mem_wb valid=1.
//      1-cycle bubble; the load moves to MEM, so load_use is false next cycle.
//    4 !imem_ready: pc_en=0, if_id_flush=1, downstream valids=1.
//    5 else: all enables 1, flushes 0.
//  MEM_WAIT: freeze as case 1 while !mem_ready, incrementing wait count.
//    Cycle mem_ready=1: evaluate RUN cases 2-5 (mem_busy false); next RUN.
//    Wait count reaching MEM_TIMEOUT with mem_ready=0 -> ERROR.
//    In the same cycle, mem_ready wins over timeout.
//  ERROR: freeze (all enables 0, flushes 0), err=1, held until reset.
//  Flushes are never asserted together with a freeze. Counters saturate at all-ones, never wrap.
//  Mid-operation reset: immediate return to BOOT outputs, wait/boot counts cleared.
// STRUCTURE
//  Package pipe_ctrl_pkg: state enum, REG_W=5, REG_ZERO=5'd0.
//  Sub-module hazard_detect: combinational load_use compare, instantiated once.
//  Top holds FSM, boot/wait counters and saturating perf counters.
// TESTING
//  T1 reset, release -> 2 cycles pc_en=0 and flushes=1, then cycle 3 all enables=1.
//  T2 ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle pc_en=0, if_id_valid=0,
//     id_ex_flush=1; next cycle all enables=1; stall_cnt +1.
//  T3 load_use and ex_redirect same cycle -> redirect wins: if_id/id_ex flush=1, pc_en=1,
//     flush_cnt +1. ex_rd=0 with a matching load -> no stall.
//  T4 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, release on 4th,
//     stall_cnt +3.
//  T5 mem_ready held 0 for MEM_TIMEOUT cycles -> ERROR, err=1, frozen; reset clears err.
//  T6 reset asserted during MEM_WAIT -> outputs go to BOOT values asynchronously; counters=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signals between the hazard controller (master) and the pipeline datapath (slave).
interface pipeline_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic             imem_ready;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_valid;
  logic             if_id_flush;
  logic             id_ex_valid;
  logic             id_ex_flush;
  logic             ex_mem_valid;
  logic             mem_wb_valid;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_redirect, imem_ready, mem_req, mem_ready,
    output pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
           ex_mem_valid, mem_wb_valid, err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_redirect, imem_ready, mem_req, mem_ready,
    input  pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
           ex_mem_valid, mem_wb_valid, err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detection: the ID instruction reads a register that a load in EX is about to write.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
  // x0 is hardwired, so a load targeting it never creates a real dependency
  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: boot priming, hazard stalls/flushes, memory-wait watchdog, perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.master bus
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            next_state;
  logic [BOOT_W-1:0] boot_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic load_use;
  logic mem_busy;
  logic frozen;
  logic boot_done;
  logic wait_expired;
  logic stall_event;
  logic redirect_taken;

  logic pc_en;
  logic if_id_valid;
  logic if_id_flush;
  logic id_ex_valid;
  logic id_ex_flush;
  logic ex_mem_valid;
  logic mem_wb_valid;
  logic err;

  hazard_detect u_hazard (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_rs1_used (bus.id_rs1_used),
    .id_rs2_used (bus.id_rs2_used),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_busy     = bus.mem_req && !bus.mem_ready;
  // Once waiting, only mem_ready matters; mem_req is assumed held by the frozen MEM stage
  assign frozen       = (state == ST_RUN) ? mem_busy : !bus.mem_ready;
  assign boot_done    = (boot_cnt == BOOT_W'(BOOT_CYCLES - 1));
  assign wait_expired = (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));
  assign stall_event  = ((state == ST_RUN) || (state == ST_MEM_WAIT)) && !pc_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_BOOT:     if (boot_done) next_state = ST_RUN;
      ST_RUN:      if (mem_busy) next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (bus.mem_ready)     next_state = ST_RUN;
        else if (wait_expired) next_state = ST_ERROR;
      end
      ST_ERROR:    next_state = ST_ERROR;
      default:     next_state = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_en          = 1'b0;
    if_id_valid    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_valid    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_valid   = 1'b0;
    mem_wb_valid   = 1'b0;
    err            = 1'b0;
    redirect_taken = 1'b0;
    unique case (state)
      ST_BOOT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (!frozen) begin
          ex_mem_valid = 1'b1;
          mem_wb_valid = 1'b1;
          if (bus.ex_redirect) begin
            pc_en          = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_taken = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            if_id_flush = 1'b1;
            id_ex_valid = 1'b1;
          end else begin
            pc_en       = 1'b1;
            if_id_valid = 1'b1;
            id_ex_valid = 1'b1;
          end
        end
      end
      ST_ERROR: err = 1'b1;
      default: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_cnt  <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == ST_BOOT) && !boot_done) boot_cnt <= boot_cnt + BOOT_W'(1);
      if (state == ST_RUN)
        wait_cnt <= mem_busy ? WAIT_W'(1) : '0;
      else if ((state == ST_MEM_WAIT) && !bus.mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (stall_event && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_valid  = if_id_valid;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_valid  = id_ex_valid;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_valid = ex_mem_valid;
  assign bus.mem_wb_valid = mem_wb_valid;
  assign bus.err          = err;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: boot, hazards, memory wait, watchdog, async reset, counter saturation.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 6;
  localparam int CNT_W       = 8;

  // {pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush, ex_mem_valid, mem_wb_valid}
  localparam logic [6:0] V_BOOT    = 7'b0010100;
  localparam logic [6:0] V_RUN     = 7'b1101011;
  localparam logic [6:0] V_FREEZE  = 7'b0000000;
  localparam logic [6:0] V_REDIR   = 7'b1010111;
  localparam logic [6:0] V_LOADUSE = 7'b0000111;
  localparam logic [6:0] V_IWAIT   = 7'b0011011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] ctrl_vec;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(
    .BOOT_CYCLES (BOOT_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {bus.pc_en, bus.if_id_valid, bus.if_id_flush, bus.id_ex_valid,
                     bus.id_ex_flush, bus.ex_mem_valid, bus.mem_wb_valid};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic rs1u,
                       input logic rs2u, input logic [4:0] rd, input logic mrd,
                       input logic redir, input logic iready, input logic mreq,
                       input logic mready);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = rs1u;
    bus.id_rs2_used = rs2u;
    bus.ex_rd       = rd;
    bus.ex_mem_read = mrd;
    bus.ex_redirect = redir;
    bus.imem_ready  = iready;
    bus.mem_req     = mreq;
    bus.mem_ready   = mready;
  endtask

  // One cycle: drive at the falling edge, let combinational outputs settle before sampling
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic rs1u,
                               input logic rs2u, input logic [4:0] rd, input logic mrd,
                               input logic redir, input logic iready, input logic mreq,
                               input logic mready);
    @(negedge clk);
    drive(rs1, rs2, rs1u, rs2u, rd, mrd, redir, iready, mreq, mready);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic memCycle(input logic redir, input logic mready);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, redir, 1'b1, 1'b1, mready);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
  endtask

  task automatic checkBootSequence(input string tag);
    checkOutput({tag, "_boot1"}, ctrl_vec, V_BOOT);
    idleCycle();
    checkOutput({tag, "_boot2"}, ctrl_vec, V_BOOT);
    idleCycle();
    checkOutput({tag, "_run"}, ctrl_vec, V_RUN);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_vec"}, ctrl_vec, V_BOOT);
    checkOutput({tag, "_err"}, bus.err, 0);
    checkOutput({tag, "_stall"}, bus.stall_cnt, 0);
    checkOutput({tag, "_flush"}, bus.flush_cnt, 0);
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkResetState("t1_in_reset");

    releaseReset();
    checkBootSequence("t1");

    // Load-use on rs1, then on rs2; an unused matching rs2 must not stall
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_lu_rs1", ctrl_vec, V_LOADUSE);
    idleCycle();
    checkOutput("t2_after_lu", ctrl_vec, V_RUN);
    checkOutput("t2_stall1", bus.stall_cnt, 1);
    applyStimulus(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_lu_rs2", ctrl_vec, V_LOADUSE);
    applyStimulus(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_rs2_unused", ctrl_vec, V_RUN);
    checkOutput("t2_stall2", bus.stall_cnt, 2);

    // Redirect beats load-use; load into x0 is not a hazard; fetch wait
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_redir_over_lu", ctrl_vec, V_REDIR);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_rd_zero", ctrl_vec, V_RUN);
    checkOutput("t3_flush1", bus.flush_cnt, 1);
    checkOutput("t3_stall_same", bus.stall_cnt, 2);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_imem_wait", ctrl_vec, V_IWAIT);
    idleCycle();
    checkOutput("t3_stall3", bus.stall_cnt, 3);

    // Memory busy beats redirect; three frozen cycles, release on the fourth
    memCycle(1'b1, 1'b0);
    checkOutput("t4_freeze1", ctrl_vec, V_FREEZE);
    memCycle(1'b0, 1'b0);
    checkOutput("t4_freeze2", ctrl_vec, V_FREEZE);
    memCycle(1'b0, 1'b0);
    checkOutput("t4_freeze3", ctrl_vec, V_FREEZE);
    memCycle(1'b0, 1'b1);
    checkOutput("t4_release", ctrl_vec, V_RUN);
    idleCycle();
    checkOutput("t4_stall6", bus.stall_cnt, 6);
    checkOutput("t4_flush_same", bus.flush_cnt, 1);
    memCycle(1'b0, 1'b0);
    memCycle(1'b1, 1'b1);
    checkOutput("t4_release_redir", ctrl_vec, V_REDIR);
    idleCycle();
    checkOutput("t4_stall7", bus.stall_cnt, 7);
    checkOutput("t4_flush2", bus.flush_cnt, 2);

    // mem_ready arriving exactly at the timeout cycle still releases
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) memCycle(1'b0, 1'b0);
    memCycle(1'b0, 1'b1);
    checkOutput("t5_ready_at_limit", ctrl_vec, V_RUN);
    checkOutput("t5_no_err", bus.err, 0);
    idleCycle();
    checkOutput("t5_stall12", bus.stall_cnt, 12);

    // Full timeout: MEM_TIMEOUT frozen cycles, then sticky error
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      memCycle(1'b0, 1'b0);
      checkOutput($sformatf("t5_wait%0d_vec", i), ctrl_vec, V_FREEZE);
      checkOutput($sformatf("t5_wait%0d_err", i), bus.err, 0);
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_err_set", bus.err, 1);
    checkOutput("t5_err_frozen", ctrl_vec, V_FREEZE);
    idleCycle();
    checkOutput("t5_err_sticky", bus.err, 1);
    checkOutput("t5_stall18", bus.stall_cnt, 18);
    checkOutput("t5_flush_same", bus.flush_cnt, 2);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("t5_reset");

    // Asynchronous reset in the middle of a memory wait
    releaseReset();
    checkBootSequence("t6_pre");
    memCycle(1'b0, 1'b0);
    memCycle(1'b0, 1'b0);
    checkOutput("t6_waiting", ctrl_vec, V_FREEZE);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("t6_async");
    releaseReset();
    checkBootSequence("t6_post");

    // flush_cnt saturates at all-ones
    for (int i = 0; i < 255; i++)
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("sat_flush_max", bus.flush_cnt, 255);
    for (int i = 0; i < 5; i++)
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("sat_flush_hold", bus.flush_cnt, 255);
    checkOutput("sat_stall_zero", bus.stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
